// File: rtl/mux_arb_rr_if.sv
// Handshake bundle for mux_arb_rr: per-channel requests in, one registered word out.
// Ports: mode/sel (arbitration control), in_valid/in_data/in_ready (per channel),
//        out_valid/out_ready/out_data/out_ch (output stage), in_lock when MUX_ARB_LOCK_EN is defined.
// Modports: master = requester/consumer side (test or parent), slave = the mux itself.
interface mux_arb_rr_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
);
   localparam int SEL_W = $clog2(NCH);

   logic                   mode;
   logic [SEL_W-1:0]       sel;
   logic [NCH-1:0]         in_valid;
   logic [NCH*WIDTH-1:0]   in_data;
   logic [NCH-1:0]         in_ready;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic [SEL_W-1:0]       out_ch;
`ifdef MUX_ARB_LOCK_EN
   logic [NCH-1:0]         in_lock;

   modport master (
      output mode, sel, in_valid, in_data, in_lock, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );
   modport slave (
      input  mode, sel, in_valid, in_data, in_lock, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
`else
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );
   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
`endif
endinterface

// File: rtl/mux_arb_rr.sv
// N-channel registered mux with fixed-select or round-robin arbitration; single output register.
// Latency: a word accepted at edge t is on out_* after edge t; one word per cycle sustained.
// Backpressure: while out_valid=1 and out_ready=0 the output holds and every in_ready is 0.
// Ports: clk, rst_n (synchronous, active-low), bus (mux_arb_rr_if.slave) carrying mode, sel,
//        in_valid/in_data/in_ready, out_valid/out_ready/out_data/out_ch.
// Optional macro MUX_ARB_LOCK_EN adds bus.in_lock: a transfer with in_lock[g]=1 pins the
// next grants to channel g until it transfers with in_lock=0 or drops in_valid while loadable.
module mux_arb_rr #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input logic        clk,
   input logic        rst_n,
   mux_arb_rr_if.slave bus
);
   localparam int SEL_W = $clog2(NCH);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NCH - 1);

   // Output stage and round-robin pointer
   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_data_q;
   logic [SEL_W-1:0]     out_ch_q;
   logic [SEL_W-1:0]     last_q;

   // Burst lock state (constant zero when the lock feature is compiled out)
   logic                 lock_act;
   logic [SEL_W-1:0]     lock_ch;

   logic                 load;
   logic                 sel_ok;
   logic                 rr_found;
   logic [SEL_W-1:0]     rr_ch;
   logic [SEL_W-1:0]     idx_s;
   logic [SEL_W-1:0]     cand;
   logic                 cand_ok;
   logic                 gnt;
   logic [WIDTH-1:0]     ch_data [NCH];

   // Unpack the flat data bus into one word per channel
   for (genvar k = 0; k < NCH; k++) begin : g_unpack
      assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
   end

   // The output register can take a new word when empty or being drained this cycle
   assign load = !out_valid_q || bus.out_ready;

   // sel may exceed NCH-1 when NCH is not a power of two; such a sel selects nothing
   assign sel_ok = (int'(bus.sel) < NCH);

   // Round-robin: first requester after the last granted channel, wrapping modulo NCH.
   // Starting at last+1 and ending at last itself gives the previous winner lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_ch    = '0;
      idx_s    = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx_s = SEL_W'((int'(last_q) + i) % NCH);
         if (!rr_found && bus.in_valid[idx_s]) begin
            rr_found = 1'b1;
            rr_ch    = idx_s;
         end
      end
   end

   // Candidate channel: an active lock wins over both modes
   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      if (lock_act) begin
         cand    = lock_ch;
         cand_ok = bus.in_valid[lock_ch];
      end else if (!bus.mode) begin
         cand    = bus.sel;
         cand_ok = sel_ok && bus.in_valid[bus.sel];
      end else begin
         cand    = rr_ch;
         cand_ok = rr_found;
      end
   end

   assign gnt = load && cand_ok;

   // One-hot accept to the granted channel only
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         bus.in_ready[k] = gnt && (cand == SEL_W'(k));
      end
   end

   // Output register. With no grant but a drain, the word leaves and out_valid drops;
   // data and channel keep their last values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         last_q      <= LAST_RST;
      end else if (gnt) begin
         out_valid_q <= 1'b1;
         out_data_q  <= ch_data[cand];
         out_ch_q    <= cand;
         // Pointer also tracks fixed-select grants so a later switch to round-robin stays fair
         last_q      <= cand;
      end else if (load) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef MUX_ARB_LOCK_EN
   // Lock is re-evaluated on every transfer; a locked channel that stops requesting
   // while the output could accept it releases the lock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_act <= 1'b0;
         lock_ch  <= '0;
      end else if (gnt) begin
         lock_act <= bus.in_lock[cand];
         lock_ch  <= cand;
      end else if (load && lock_act && !bus.in_valid[lock_ch]) begin
         lock_act <= 1'b0;
      end
   end
`else
   assign lock_act = 1'b0;
   assign lock_ch  = '0;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule
